seven_seg_display: RTL and testbench

- Registered 8-digit hexadecimal seven-segment driver.
- Converts a 32-bit data word into eight 7-segment patterns, one hex digit (nibble) per display.
- Sits inside the board I/O block. It continuously shows the word last written by the CPU to the display register.
- Outputs drive the board displays directly.

---
 rtl/seven_seg_display_pkg.sv | 33 +++
 rtl/seven_seg_display_if.sv | 13 +
 rtl/seven_seg_display_hex_to_7seg.sv | 15 +
 rtl/seven_seg_display.sv | 66 ++++++
 tb/tb_seven_seg_display.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_display_pkg.sv
// Shared constants for the 8-digit hexadecimal seven-segment driver:
// glyph table (active-high, gfedcba), display geometry and blank pattern.
package seven_seg_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int NIBBLE_W   = 4;
  localparam int INFO_W     = NUM_DIGITS * NIBBLE_W;
  localparam int DISP_W     = NUM_DIGITS * SEG_W;

  // Active-high "all segments off" pattern for a single digit.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Active-high glyphs indexed by nibble value; b and d are lower case so
  // they cannot be mistaken for 8 and 0.
  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Convert an active-high pattern to the board drive polarity.
  function automatic logic [SEG_W-1:0] apply_polarity(
    input logic [SEG_W-1:0] seg,
    input logic             active_low
  );
    if (active_low) begin
      return ~seg;
    end else begin
      return seg;
    end
  endfunction

endpackage

// File: rtl/seven_seg_display_if.sv
// Bus between the CPU display register and the seven-segment driver.
interface seven_seg_display_if;
  import seven_seg_display_pkg::*;

  logic [INFO_W-1:0] info;
  logic [DISP_W-1:0] SevenSegDisplays;

  // Register side: supplies the word, observes the segments.
  modport master (output info, input SevenSegDisplays);
  // Display driver side.
  modport slave  (input info, output SevenSegDisplays);

endinterface

// File: rtl/seven_seg_display_hex_to_7seg.sv
// Combinational nibble to active-high seven-segment decoder (gfedcba).
// Every nibble value has a glyph, so no code can produce X.
module hex_to_7seg
  import seven_seg_display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  output logic [SEG_W-1:0]    seg_o
);

  // Glyph lookup covering all 16 codes.
  always_comb begin
    seg_o = GLYPH_TABLE[nibble_i];
  end

endmodule

// File: rtl/seven_seg_display.sv
// Registered 8-digit hex seven-segment driver. Each nibble of info is
// decoded in parallel, optionally leading-zero blanked, converted to the
// board polarity and registered (one cycle latency).
module seven_seg_display
  import seven_seg_display_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  seven_seg_display_if.slave bus
);

  logic [SEG_W-1:0]  glyph_s [NUM_DIGITS];
  logic [DISP_W-1:0] disp_d;
  logic [DISP_W-1:0] disp_q;
  logic [DISP_W-1:0] disp_off_s;

  // One decoder per digit, all working in parallel.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    hex_to_7seg u_hex_to_7seg (
      .nibble_i (bus.info[NIBBLE_W*k +: NIBBLE_W]),
      .seg_o    (glyph_s[k])
    );
  end

  // Whole-display "all off" pattern in board polarity, used for reset.
  always_comb begin
    disp_off_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      disp_off_s[SEG_W*k +: SEG_W] = apply_polarity(SEG_BLANK, ACTIVE_LOW);
    end
  end

  // Blanking from the top digit down, then polarity, forming the next output.
  always_comb begin
    logic             upper_zero;
    logic [SEG_W-1:0] seg;
    disp_d     = '0;
    upper_zero = 1'b1;
    seg        = SEG_BLANK;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (bus.info[NIBBLE_W*k +: NIBBLE_W] == 4'h0);
      // Digit 0 is never blanked so a zero word still shows "0".
      if (BLANK_LEADING && (k != 0) && upper_zero) begin
        seg = SEG_BLANK;
      end else begin
        seg = glyph_s[k];
      end
      disp_d[SEG_W*k +: SEG_W] = apply_polarity(seg, ACTIVE_LOW);
    end
  end

  // Output register with synchronous reset to all segments off.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_q <= disp_off_s;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign bus.SevenSegDisplays = disp_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display: three configurations share clock,
// reset and info (low/plain, low/blanking, high/plain).
module tb_seven_seg_display;

  logic        clock;
  logic        reset;
  logic [31:0] info;
  int          n_cmp;
  int          n_err;

  seven_seg_display_if if_lo ();
  seven_seg_display_if if_bl ();
  seven_seg_display_if if_hi ();

  assign if_lo.info = info;
  assign if_bl.info = info;
  assign if_hi.info = info;

  seven_seg_display #(.ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_lo (
    .clock (clock), .reset (reset), .bus (if_lo.slave));
  seven_seg_display #(.ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_bl (
    .clock (clock), .reset (reset), .bus (if_bl.slave));
  seven_seg_display #(.ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_hi (
    .clock (clock), .reset (reset), .bus (if_hi.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    info  = 32'h12345678;
    step();
    n_cmp++;
    if (if_lo.SevenSegDisplays !== 56'hFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL reset_lo: got %h want %h", if_lo.SevenSegDisplays, 56'hFF_FFFF_FFFF_FFFF);
    end
    step();
    n_cmp++;
    if (if_lo.SevenSegDisplays !== 56'hFF_FFFF_FFFF_FFFF) begin
      n_err++;
      $display("FAIL reset_hold_lo: got %h want %h", if_lo.SevenSegDisplays, 56'hFF_FFFF_FFFF_FFFF);
    end
    n_cmp++;
    if (if_hi.SevenSegDisplays !== 56'h0) begin
      n_err++;
      $display("FAIL reset_hi: got %h want %h", if_hi.SevenSegDisplays, 56'h0);
    end
  endtask

  task automatic test_digits();
    logic [55:0] exp_v;
    reset = 1'b0;
    info  = 32'h76543210;
    exp_v = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    step();
    n_cmp++;
    if (if_lo.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL digits_0_7: got %h want %h", if_lo.SevenSegDisplays, exp_v);
    end
  endtask

  task automatic test_hex_letters();
    logic [55:0] exp_v;
    info  = 32'hFEDCBA98;
    exp_v = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    step();
    n_cmp++;
    if (if_lo.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL hex_letters: got %h want %h", if_lo.SevenSegDisplays, exp_v);
    end
    // Same word through the active-high instance: raw glyphs.
    exp_v = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
    n_cmp++;
    if (if_hi.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL hex_letters_hi: got %h want %h", if_hi.SevenSegDisplays, exp_v);
    end
  endtask

  task automatic test_latency();
    logic [55:0] zero_v;
    logic [55:0] one_v;
    zero_v = {8{7'h40}};
    one_v  = {{7{7'h40}}, 7'h79};
    info = 32'h0;
    step();
    n_cmp++;
    if (if_lo.SevenSegDisplays !== zero_v) begin
      n_err++;
      $display("FAIL latency_zero: got %h want %h", if_lo.SevenSegDisplays, zero_v);
    end
    info = 32'h1;
    #3;
    n_cmp++;
    if (if_lo.SevenSegDisplays !== zero_v) begin
      n_err++;
      $display("FAIL latency_before_edge: got %h want %h", if_lo.SevenSegDisplays, zero_v);
    end
    step();
    n_cmp++;
    if (if_lo.SevenSegDisplays !== one_v) begin
      n_err++;
      $display("FAIL latency_after_edge: got %h want %h", if_lo.SevenSegDisplays, one_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [4];
    logic [55:0] vexp [4];
    vin[0] = 32'h00000002; vexp[0] = {{7{7'h40}}, 7'h24};
    vin[1] = 32'h000000F0; vexp[1] = {{6{7'h40}}, 7'h0E, 7'h40};
    vin[2] = 32'h80000000; vexp[2] = {7'h00, {7{7'h40}}};
    vin[3] = 32'h33333333; vexp[3] = {8{7'h30}};
    for (int i = 0; i < 4; i++) begin
      info = vin[i];
      step();
      n_cmp++;
      if (if_lo.SevenSegDisplays !== vexp[i]) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, if_lo.SevenSegDisplays, vexp[i]);
      end
    end
  endtask

  task automatic test_blank_leading();
    logic [55:0] exp_v;
    info  = 32'h00000A05;
    step();
    exp_v = {{5{7'h7F}}, 7'h08, 7'h40, 7'h12};
    n_cmp++;
    if (if_bl.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL blank_a05: got %h want %h", if_bl.SevenSegDisplays, exp_v);
    end
    exp_v = {{5{7'h40}}, 7'h08, 7'h40, 7'h12};
    n_cmp++;
    if (if_lo.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL noblank_a05: got %h want %h", if_lo.SevenSegDisplays, exp_v);
    end
    info  = 32'h0;
    step();
    exp_v = {{7{7'h7F}}, 7'h40};
    n_cmp++;
    if (if_bl.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL blank_zero: got %h want %h", if_bl.SevenSegDisplays, exp_v);
    end
    info  = 32'h10000000;
    step();
    exp_v = {7'h79, {7{7'h40}}};
    n_cmp++;
    if (if_bl.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL blank_top_set: got %h want %h", if_bl.SevenSegDisplays, exp_v);
    end
  endtask

  task automatic test_polarity();
    logic [55:0] exp_v;
    reset = 1'b1;
    info  = 32'h00000008;
    step();
    n_cmp++;
    if (if_hi.SevenSegDisplays !== 56'h0) begin
      n_err++;
      $display("FAIL polarity_reset: got %h want %h", if_hi.SevenSegDisplays, 56'h0);
    end
    reset = 1'b0;
    step();
    exp_v = {{7{7'h3F}}, 7'h7F};
    n_cmp++;
    if (if_hi.SevenSegDisplays !== exp_v) begin
      n_err++;
      $display("FAIL polarity_release: got %h want %h", if_hi.SevenSegDisplays, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    info  = 32'h0;
    test_reset();
    test_digits();
    test_hex_letters();
    test_latency();
    test_back_to_back();
    test_blank_leading();
    test_polarity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
